// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode stall, latch nop controls and X-stage bypass
// selects for the five-stage pipeline with multi-cycle mul/div support.
// Keeps registered X/M/W destination shadows plus a per-register pending
// scoreboard for in-flight multi-cycle ops.
// Optional build macro: HAZARD_PERF_CNT_EN enables the three event counters;
// without it the perf_* outputs are tied to zero.

// Per-operand bypass select: M beats W, register 0 and unread operands
// always come from the register file.
module hazard_byp_sel #(
    parameter int RADDR = 5
) (
    input  logic             x_valid,
    input  logic             rd_en,
    input  logic [RADDR-1:0] src,
    input  logic             m_valid,
    input  logic             m_writes,
    input  logic [RADDR-1:0] m_rd,
    input  logic             w_valid,
    input  logic             w_writes,
    input  logic [RADDR-1:0] w_rd,
    output logic [1:0]       sel
);

    // Select the youngest in-flight producer of this operand.
    always_comb begin
        sel = 2'b00;
        if (x_valid && rd_en && (src != '0)) begin
            if (m_valid && m_writes && (m_rd == src)) begin
                sel = 2'b01;
            end else if (w_valid && w_writes && (w_rd == src)) begin
                sel = 2'b10;
            end
        end
    end

endmodule

module hazard_scoreboard #(
    parameter int NREGS   = 32,
    parameter int RADDR   = 5,
    parameter int MAX_OUT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [RADDR-1:0] d_rs,
    input  logic [RADDR-1:0] d_rt,
    input  logic [RADDR-1:0] d_rd,
    input  logic [2:0]       d_reads,
    input  logic             d_writes,
    input  logic             d_is_load,
    input  logic             d_is_md,
    input  logic             flush,
    input  logic             md_done,
    input  logic [RADDR-1:0] md_rd,
    output logic             stall_d,
    output logic             nop_fd,
    output logic             nop_dx,
    output logic [1:0]       byp_rs,
    output logic [1:0]       byp_rt,
    output logic [1:0]       byp_rd,
    output logic [3:0]       md_outstanding,
    output logic             md_err,
    output logic [31:0]      perf_load_stall,
    output logic [31:0]      perf_md_stall,
    output logic [31:0]      perf_flush
);

    // X keeps its source fields too, since bypass is resolved for the
    // instruction sitting in X; M and W only need the destination side.
    typedef struct packed {
        logic             valid;
        logic [RADDR-1:0] rs;
        logic [RADDR-1:0] rt;
        logic [RADDR-1:0] rd;
        logic [2:0]       reads;
        logic             writes;
        logic             is_load;
    } x_shadow_t;

    typedef struct packed {
        logic             valid;
        logic [RADDR-1:0] rd;
        logic             writes;
        logic             is_load;
    } mw_shadow_t;

    x_shadow_t              x_q, x_d;
    mw_shadow_t             m_q, m_d, w_q, w_d;
    logic [NREGS-1:0]       pending_q, pending_d;
    logic [3:0]             count_q, count_d;
    logic                   err_q, err_d;

    logic [2:0][RADDR-1:0]  d_src;
    logic [2:0][RADDR-1:0]  x_src;
    logic [2:0][1:0]        byp;
    logic                   d_wr_eff;
    logic                   load_stall;
    logic                   md_raw;
    logic                   md_waw;
    logic                   md_struct;
    logic                   md_stall;
    logic                   advance;
    logic                   issue;
    logic                   done_ok;
    logic                   done_bad;

    assign d_src    = {d_rd, d_rt, d_rs};
    assign x_src    = {x_q.rd, x_q.rt, x_q.rs};
    // A write to r0 is architecturally a no-op, so never track it.
    assign d_wr_eff = d_writes && (d_rd != '0);

    // Source hazards: load-use against X, RAW against the pending scoreboard.
    always_comb begin
        load_stall = 1'b0;
        md_raw     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (d_reads[i] && (d_src[i] != '0)) begin
                if (x_q.valid && x_q.is_load && x_q.writes && (x_q.rd == d_src[i])) begin
                    load_stall = 1'b1;
                end
                if (pending_q[d_src[i]]) begin
                    md_raw = 1'b1;
                end
            end
        end
    end

    assign md_waw    = d_wr_eff && pending_q[d_rd];
    assign md_struct = d_is_md && (count_q == 4'(MAX_OUT));
    assign md_stall  = md_raw || md_waw || md_struct;

    // Flush wins over stall: the D instruction is being discarded anyway.
    assign stall_d = d_valid && !flush && (load_stall || md_stall);
    assign nop_fd  = flush;
    assign nop_dx  = flush || stall_d;

    assign advance  = d_valid && !stall_d && !flush;
    assign issue    = advance && d_is_md && (d_rd != '0);
    assign done_ok  = md_done && pending_q[md_rd];
    assign done_bad = md_done && !pending_q[md_rd];

    // Shadow pipeline: D->X only on a clean advance, M/W always shift.
    always_comb begin
        x_d = '0;
        if (advance) begin
            x_d.valid   = 1'b1;
            x_d.rs      = d_rs;
            x_d.rt      = d_rt;
            x_d.rd      = d_rd;
            x_d.reads   = d_reads;
            x_d.writes  = d_wr_eff;
            x_d.is_load = d_is_load;
        end
        m_d.valid   = x_q.valid;
        m_d.rd      = x_q.rd;
        m_d.writes  = x_q.writes;
        m_d.is_load = x_q.is_load;
        w_d         = m_q;
    end

    // Scoreboard update; a same-register set/clear is prevented by the WAW stall.
    always_comb begin
        pending_d = pending_q;
        if (done_ok) begin
            pending_d[md_rd] = 1'b0;
        end
        if (issue) begin
            pending_d[d_rd] = 1'b1;
        end
        count_d = count_q;
        case ({issue, done_ok})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
        err_d = err_q || done_bad;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            x_q       <= x_d;
            m_q       <= m_d;
            w_q       <= w_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    // One bypass selector per X operand (rs, rt, rd).
    for (genvar g = 0; g < 3; g++) begin : g_byp
        hazard_byp_sel #(.RADDR(RADDR)) u_sel (
            .x_valid  (x_q.valid),
            .rd_en    (x_q.reads[g]),
            .src      (x_src[g]),
            .m_valid  (m_q.valid),
            .m_writes (m_q.writes),
            .m_rd     (m_q.rd),
            .w_valid  (w_q.valid),
            .w_writes (w_q.writes),
            .w_rd     (w_q.rd),
            .sel      (byp[g])
        );
    end

    assign byp_rs         = byp[0];
    assign byp_rt         = byp[1];
    assign byp_rd         = byp[2];
    assign md_outstanding = count_q;
    assign md_err         = err_q;

    // is_load is carried through M/W for debug visibility only.
    logic unused_shadow;
    assign unused_shadow = m_q.is_load ^ w_q.is_load;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_load_q, perf_load_d;
    logic [31:0] perf_md_q,   perf_md_d;
    logic [31:0] perf_fl_q,   perf_fl_d;
    logic        load_ev;
    logic        md_ev;

    // A stall cycle may count in both counters; flush suppresses stall events.
    assign load_ev = d_valid && !flush && load_stall;
    assign md_ev   = d_valid && !flush && md_stall;

    // Free-running event counters, wrapping naturally at 2^32.
    always_comb begin
        perf_load_d = perf_load_q + {31'b0, load_ev};
        perf_md_d   = perf_md_q   + {31'b0, md_ev};
        perf_fl_d   = perf_fl_q   + {31'b0, flush};
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_load_q <= '0;
            perf_md_q   <= '0;
            perf_fl_q   <= '0;
        end else begin
            perf_load_q <= perf_load_d;
            perf_md_q   <= perf_md_d;
            perf_fl_q   <= perf_fl_d;
        end
    end

    assign perf_load_stall = perf_load_q;
    assign perf_md_stall   = perf_md_q;
    assign perf_flush      = perf_fl_q;
`else
    assign perf_load_stall = '0;
    assign perf_md_stall   = '0;
    assign perf_flush      = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a driver applies one D-stage
// instruction per cycle, a reference model derives the expected outputs
// and queues them, and a monitor on the falling edge compares.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
    localparam int NREGS   = 32;
    localparam int RADDR   = 5;
    localparam int MAX_OUT = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             d_valid;
    logic [RADDR-1:0] d_rs, d_rt, d_rd;
    logic [2:0]       d_reads;
    logic             d_writes, d_is_load, d_is_md, flush, md_done;
    logic [RADDR-1:0] md_rd;
    logic             stall_d, nop_fd, nop_dx;
    logic [1:0]       byp_rs, byp_rt, byp_rd;
    logic [3:0]       md_outstanding;
    logic             md_err;
    logic [31:0]      perf_load_stall, perf_md_stall, perf_flush;

    hazard_scoreboard #(.NREGS(NREGS), .RADDR(RADDR), .MAX_OUT(MAX_OUT)) dut (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_rd(d_rd), .d_reads(d_reads), .d_writes(d_writes), .d_is_load(d_is_load),
        .d_is_md(d_is_md), .flush(flush), .md_done(md_done), .md_rd(md_rd),
        .stall_d(stall_d), .nop_fd(nop_fd), .nop_dx(nop_dx), .byp_rs(byp_rs),
        .byp_rt(byp_rt), .byp_rd(byp_rd), .md_outstanding(md_outstanding),
        .md_err(md_err), .perf_load_stall(perf_load_stall),
        .perf_md_stall(perf_md_stall), .perf_flush(perf_flush)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit rst, v;
        int rs, rt, rd;
        bit [2:0] reads;
        bit wr, ld, md, fl, mdd;
        int mdrd;
    } stim_t;

    typedef struct packed {
        logic        stall, nfd, ndx;
        logic [1:0]  brs, brt, brd;
        logic [3:0]  cnt;
        logic        err;
        logic [31:0] pl, pm, pf;
    } exp_t;

    // Reference model: an instruction list for X/M/W and a set of pending registers.
    typedef struct {
        bit v;
        int rs, rt, rd;
        bit [2:0] reads;
        bit wr, ld;
    } ins_t;

    ins_t        sx, sm, sw;
    bit          pend [NREGS];
    bit          m_err;
    int unsigned c_load, c_md, c_fl;

    exp_t        expq [$];
    bit          active = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_no = 0;
    exp_t        last_e;
    stim_t       last_s;

    function automatic int npend();
        int n = 0;
        for (int r = 0; r < NREGS; r++) n += int'(pend[r]);
        return n;
    endfunction

    function automatic logic [1:0] byp_of(int src, bit used);
        if (!sx.v || !used || src == 0) return 2'b00;
        if (sm.v && sm.wr && sm.rd == src) return 2'b01;
        if (sw.v && sw.wr && sw.rd == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s.rst = 0; s.v = 0; s.rs = 0; s.rt = 0; s.rd = 0; s.reads = 3'b000;
        s.wr = 0; s.ld = 0; s.md = 0; s.fl = 0; s.mdd = 0; s.mdrd = 0;
        return s;
    endfunction

    function automatic stim_t op(int rd, int rs, int rt, bit [2:0] reads, bit ld, bit md);
        stim_t s = nop();
        s.v = 1; s.rd = rd; s.rs = rs; s.rt = rt; s.reads = reads;
        s.wr = 1; s.ld = ld; s.md = md;
        return s;
    endfunction

    // Evaluate one cycle of the model: outputs first, then advance state.
    task automatic step(input stim_t s, output exp_t e);
        int   src [3];
        bit   lst, mst, adv;
        int   np;
        ins_t ni;
        src[0] = s.rs; src[1] = s.rt; src[2] = s.rd;
        np  = npend();
        lst = 0; mst = 0;
        for (int i = 0; i < 3; i++) begin
            if (s.reads[i] && src[i] != 0) begin
                if (sx.v && sx.ld && sx.wr && sx.rd == src[i]) lst = 1;
                if (pend[src[i]]) mst = 1;
            end
        end
        if (s.wr && s.rd != 0 && pend[s.rd]) mst = 1;
        if (s.md && np == MAX_OUT) mst = 1;
        e.stall = s.v && !s.fl && (lst || mst);
        e.nfd   = s.fl;
        e.ndx   = s.fl || e.stall;
        e.brs   = byp_of(sx.rs, sx.reads[0]);
        e.brt   = byp_of(sx.rt, sx.reads[1]);
        e.brd   = byp_of(sx.rd, sx.reads[2]);
        e.cnt   = 4'(np);
        e.err   = m_err;
`ifdef HAZARD_PERF_CNT_EN
        e.pl = c_load; e.pm = c_md; e.pf = c_fl;
`else
        e.pl = 0; e.pm = 0; e.pf = 0;
`endif
        if (s.rst) begin
            sx = '{default: 0}; sm = '{default: 0}; sw = '{default: 0};
            for (int r = 0; r < NREGS; r++) pend[r] = 0;
            m_err = 0; c_load = 0; c_md = 0; c_fl = 0;
        end else begin
            adv = s.v && !e.stall && !s.fl;
            if (s.mdd) begin
                if (s.mdrd != 0 && pend[s.mdrd]) pend[s.mdrd] = 0;
                else m_err = 1;
            end
            if (adv && s.md && s.rd != 0) pend[s.rd] = 1;
            if (s.v && !s.fl && lst) c_load++;
            if (s.v && !s.fl && mst) c_md++;
            if (s.fl) c_fl++;
            ni.v = adv; ni.rs = s.rs; ni.rt = s.rt; ni.rd = s.rd;
            ni.reads = s.reads; ni.wr = s.wr && s.rd != 0; ni.ld = s.ld;
            if (!adv) ni = '{default: 0};
            sw = sm; sm = sx; sx = ni;
        end
    endtask

    task automatic cyc(input stim_t s);
        exp_t e;
        @(posedge clock); #1;
        reset     = s.rst;
        d_valid   = s.v;
        d_rs      = RADDR'(s.rs);
        d_rt      = RADDR'(s.rt);
        d_rd      = RADDR'(s.rd);
        d_reads   = s.reads;
        d_writes  = s.wr;
        d_is_load = s.ld;
        d_is_md   = s.md;
        flush     = s.fl;
        md_done   = s.mdd;
        md_rd     = RADDR'(s.mdrd);
        step(s, e);
        expq.push_back(e);
        active = 1'b1;
        last_e = e;
        last_s = s;
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clock);
            if (active) begin
                cyc_no++;
                a = {stall_d, nop_fd, nop_dx, byp_rs, byp_rt, byp_rd, md_outstanding,
                     md_err, perf_load_stall, perf_md_stall, perf_flush};
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL cycle %0d: no expected record queued", cyc_no);
                end else begin
                    e = expq.pop_front();
                    if (a !== e) begin
                        n_bad++;
                        $display("FAIL cycle %0d: got stall=%b nfd=%b ndx=%b byp=%b/%b/%b cnt=%0d err=%b perf=%0d/%0d/%0d, required stall=%b nfd=%b ndx=%b byp=%b/%b/%b cnt=%0d err=%b perf=%0d/%0d/%0d",
                                 cyc_no, a.stall, a.nfd, a.ndx, a.brs, a.brt, a.brd, a.cnt, a.err, a.pl, a.pm, a.pf,
                                 e.stall, e.nfd, e.ndx, e.brs, e.brt, e.brd, e.cnt, e.err, e.pl, e.pm, e.pf);
                    end
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    pl [$];
        reset = 1'b1; d_valid = 0; d_rs = '0; d_rt = '0; d_rd = '0; d_reads = '0;
        d_writes = 0; d_is_load = 0; d_is_md = 0; flush = 0; md_done = 0; md_rd = '0;
        sx = '{default: 0}; sm = '{default: 0}; sw = '{default: 0};
        for (int r = 0; r < NREGS; r++) pend[r] = 0;
        m_err = 0; c_load = 0; c_md = 0; c_fl = 0;
        repeat (2) @(posedge clock);

        // Reset state with an idle D stage.
        cyc(nop());
        cyc(nop());

        // Load-use: lw r5; add r6,r5,r1 stalls once, then bypasses from W.
        cyc(op(5, 1, 0, 3'b001, 1, 0));
        cyc(op(6, 5, 1, 3'b011, 0, 0));
        cyc(op(6, 5, 1, 3'b011, 0, 0));
        cyc(nop());
        cyc(nop());
        cyc(nop());

        // M wins over W: add r3; add r3; add r4,r3,r3.
        cyc(op(3, 1, 2, 3'b011, 0, 0));
        cyc(op(3, 1, 2, 3'b011, 0, 0));
        cyc(op(4, 3, 3, 3'b011, 0, 0));
        cyc(nop());
        cyc(nop());
        cyc(nop());

        // MD RAW: mul r7; sub r8,r7,r2 held until the cycle after md_done(7).
        cyc(op(7, 1, 2, 3'b011, 0, 1));
        repeat (3) cyc(op(8, 7, 2, 3'b011, 0, 0));
        s = op(8, 7, 2, 3'b011, 0, 0); s.mdd = 1; s.mdrd = 7;
        cyc(s);
        cyc(op(8, 7, 2, 3'b011, 0, 0));
        cyc(nop());

        // Structural: two divs outstanding, third blocked; md_done frees a slot.
        cyc(op(10, 1, 2, 3'b011, 0, 1));
        cyc(op(11, 1, 2, 3'b011, 0, 1));
        cyc(op(12, 1, 2, 3'b011, 0, 1));
        s = op(12, 1, 2, 3'b011, 0, 1); s.mdd = 1; s.mdrd = 10;
        cyc(s);
        cyc(op(12, 1, 2, 3'b011, 0, 1));
        s = nop(); s.mdd = 1; s.mdrd = 11; cyc(s);
        s = nop(); s.mdd = 1; s.mdrd = 12; cyc(s);
        cyc(nop());

        // Flush overrides a load-use stall.
        cyc(op(5, 1, 0, 3'b001, 1, 0));
        s = op(6, 5, 1, 3'b011, 0, 0); s.fl = 1;
        cyc(s);
        cyc(nop());
        cyc(nop());

        // md_done for a non-pending register is sticky until reset.
        s = nop(); s.mdd = 1; s.mdrd = 9; cyc(s);
        cyc(nop());
        cyc(nop());
        s = nop(); s.rst = 1; cyc(s);
        cyc(nop());

        // Reset mid-mul drops the pending op; its late md_done is an error.
        cyc(op(7, 1, 2, 3'b011, 0, 1));
        cyc(nop());
        s = nop(); s.rst = 1; cyc(s);
        cyc(op(8, 7, 2, 3'b011, 0, 0));
        s = nop(); s.mdd = 1; s.mdrd = 7; cyc(s);
        cyc(nop());
        s = nop(); s.rst = 1; cyc(s);

        // Randomized traffic on a small register window to force hazards.
        for (int n = 0; n < 800; n++) begin
            int k;
            if (last_e.stall && !last_s.rst) begin
                s = last_s;
            end else begin
                k = int'($urandom_range(0, 9));
                s = nop();
                s.v  = ($urandom_range(0, 9) != 0);
                s.rs = int'($urandom_range(0, 7));
                s.rt = int'($urandom_range(0, 7));
                s.reads = 3'($urandom_range(0, 7));
                s.wr = 1;
                if (k < 2) begin
                    s.ld = 1; s.rd = int'($urandom_range(1, 7));
                end else if (k == 2) begin
                    s.md = 1; s.rd = int'($urandom_range(1, 7));
                end else begin
                    s.rd = int'($urandom_range(0, 7));
                    s.wr = ($urandom_range(0, 3) != 0);
                end
            end
            s.rst = ($urandom_range(0, 99) == 0);
            s.fl  = ($urandom_range(0, 11) == 0);
            s.mdd = 0; s.mdrd = 0;
            pl = {};
            for (int r = 0; r < NREGS; r++) if (pend[r]) pl.push_back(r);
            if (pl.size() != 0 && $urandom_range(0, 3) == 0) begin
                s.mdd = 1; s.mdrd = pl[$urandom_range(0, pl.size() - 1)];
            end else if ($urandom_range(0, 49) == 0) begin
                s.mdd = 1; s.mdrd = int'($urandom_range(0, 15));
            end
            cyc(s);
        end
        cyc(nop());

        @(negedge clock);
        #1;
        if (expq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected records left, required 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
